// File: rtl/snake_body_engine.sv
// Purpose: snake game state on a 40x30 grid; moves, grows, detects collisions, answers pixel queries.
// Latency: a move commits on the edge after move_tick; snake (cell type) is registered, 1 cycle after x_pos/y_pos.
// Backpressure: none; move_tick/grow/restart are single-cycle pulses, queries are accepted every cycle.
// Ports: clk, rst (sync active-low); move_tick, dir_in[1:0] (00 up,01 down,10 left,11 right), grow, restart;
//        x_pos/y_pos[9:0] pixel query -> snake[1:0] (00 none,01 head,10 body,11 wall);
//        head_x[5:0], head_y[4:0], length[4:0], game_over.
module snake_body_engine #(
    parameter int MAX_LEN  = 16,
    parameter int INIT_LEN = 3,
    parameter int GRID_W   = 40,
    parameter int GRID_H   = 30
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       move_tick,
    input  logic [1:0] dir_in,
    input  logic       grow,
    input  logic       restart,
    input  logic [9:0] x_pos,
    input  logic [9:0] y_pos,
    output logic [1:0] snake,
    output logic [5:0] head_x,
    output logic [4:0] head_y,
    output logic [4:0] length,
    output logic       game_over
);

    typedef enum logic [1:0] {S_INIT, S_RUN, S_DEAD} state_t;

    localparam logic [5:0] X_LAST = 6'(GRID_W - 1);
    localparam logic [4:0] Y_LAST = 5'(GRID_H - 1);
    localparam logic [9:0] X_PIX  = 10'(GRID_W * 16);
    localparam logic [9:0] Y_PIX  = 10'(GRID_H * 16);

    state_t     state, state_nxt;
    logic [5:0] seg_x [MAX_LEN];
    logic [4:0] seg_y [MAX_LEN];
    logic [1:0] dir, dir_req, mv_dir;
    logic       grow_pend, eff_grow;
    logic [4:0] len_q;
    logic [5:0] nh_x;
    logic [4:0] nh_y;
    logic       do_move, hit_wall, hit_body, collide, commit, run;
    logic [5:0] qx;
    logic [4:0] qy;
    logic       q_out, q_wall, q_head, q_body;
    logic [1:0] snake_nxt;

    // ---------------- move datapath ----------------
    always_comb begin
        eff_grow = grow_pend | grow;
        // Reversal onto the neck is discarded: same axis (bit1), other sense (bit0).
        if ((dir_req[1] == dir[1]) && (dir_req[0] != dir[0])) mv_dir = dir;
        else                                                  mv_dir = dir_req;
        nh_x = seg_x[0];
        nh_y = seg_y[0];
        case (mv_dir)
            2'b00:   nh_y = seg_y[0] - 5'd1;
            2'b01:   nh_y = seg_y[0] + 5'd1;
            2'b10:   nh_x = seg_x[0] - 6'd1;
            default: nh_x = seg_x[0] + 6'd1;
        endcase
        hit_wall = (nh_x == 6'd0) || (nh_x == X_LAST) || (nh_y == 5'd0) || (nh_y == Y_LAST);
        hit_body = 1'b0;
        for (int i = 0; i < MAX_LEN; i++) begin
            // The tail cell is vacated by this same move unless the snake is growing.
            if ((5'(i) < len_q) && ((5'(i) != len_q - 5'd1) || eff_grow) &&
                (seg_x[i] == nh_x) && (seg_y[i] == nh_y))
                hit_body = 1'b1;
        end
        collide = hit_wall | hit_body;
    end

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (!rst || restart) state <= S_INIT;
        else                 state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_INIT:  state_nxt = S_RUN;
            S_RUN:   if (move_tick && collide) state_nxt = S_DEAD;
            S_DEAD:  state_nxt = S_DEAD;
            default: state_nxt = S_INIT;
        endcase
    end

    always_comb begin
        run       = (state == S_RUN);
        game_over = (state == S_DEAD);
        do_move   = run && move_tick;
        commit    = do_move && !collide;
    end

    // ---------------- snake state ----------------
    always_ff @(posedge clk) begin
        if (!rst || restart) begin
            for (int i = 0; i < MAX_LEN; i++) begin
                seg_x[i] <= 6'(GRID_W / 2 - i);
                seg_y[i] <= 5'(GRID_H / 2);
            end
            dir       <= 2'b11;
            dir_req   <= 2'b11;
            grow_pend <= 1'b0;
            len_q     <= 5'(INIT_LEN);
        end else begin
            if (run) dir_req <= dir_in;
            if (do_move)   grow_pend <= 1'b0;
            else if (grow) grow_pend <= 1'b1;
            if (commit) begin
                for (int i = 1; i < MAX_LEN; i++) begin
                    seg_x[i] <= seg_x[i-1];
                    seg_y[i] <= seg_y[i-1];
                end
                seg_x[0] <= nh_x;
                seg_y[0] <= nh_y;
                dir      <= mv_dir;
                // At MAX_LEN the shift simply pushes the tail out of the counted range.
                if (eff_grow && (len_q < 5'(MAX_LEN))) len_q <= len_q + 5'd1;
            end
        end
    end

    assign head_x = seg_x[0];
    assign head_y = seg_y[0];
    assign length = len_q;

    // ---------------- pixel query ----------------
    always_comb begin
        qx     = x_pos[9:4];
        qy     = y_pos[9:4];
        q_out  = (x_pos >= X_PIX) || (y_pos >= Y_PIX);
        q_wall = (qx == 6'd0) || (qx == X_LAST) || (qy == 5'd0) || (qy == Y_LAST);
        q_head = (qx == seg_x[0]) && (qy == seg_y[0]);
        q_body = 1'b0;
        for (int i = 1; i < MAX_LEN; i++) begin
            if ((5'(i) < len_q) && (seg_x[i] == qx) && (seg_y[i] == qy)) q_body = 1'b1;
        end
        if (q_out)       snake_nxt = 2'b00;
        else if (q_wall) snake_nxt = 2'b11;
        else if (q_head) snake_nxt = 2'b01;
        else if (q_body) snake_nxt = 2'b10;
        else             snake_nxt = 2'b00;
    end

    always_ff @(posedge clk) begin
        if (!rst || restart) snake <= 2'b00;
        else                 snake <= snake_nxt;
    end

endmodule

// File: tb/tb_snake_body_engine.sv
module tb_snake_body_engine;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       move_tick = 1'b0;
    logic [1:0] dir_in = 2'b11;
    logic       grow = 1'b0;
    logic       restart = 1'b0;
    logic [9:0] x_pos = 10'd0;
    logic [9:0] y_pos = 10'd0;
    logic [1:0] snake;
    logic [5:0] head_x;
    logic [4:0] head_y;
    logic [4:0] length;
    logic       game_over;

    int n_vec = 0;
    int n_err = 0;

    snake_body_engine dut (
        .clk(clk), .rst(rst), .move_tick(move_tick), .dir_in(dir_in), .grow(grow),
        .restart(restart), .x_pos(x_pos), .y_pos(y_pos), .snake(snake),
        .head_x(head_x), .head_y(head_y), .length(length), .game_over(game_over)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    // Hold the direction for a cycle before the move so dir_req is settled.
    task automatic step(input logic [1:0] d, input logic g);
        dir_in = d;
        tick();
        move_tick = 1'b1;
        grow = g;
        tick();
        move_tick = 1'b0;
        grow = 1'b0;
    endtask

    task automatic query(input int x, input int y, input logic [1:0] exp, input string tag);
        x_pos = 10'(x);
        y_pos = 10'(y);
        tick();
        chk(tag, 32'(snake), 32'(exp));
    endtask

    initial begin
        // 1: reset state and queries of the initial snake
        do_reset();
        rst = 1'b0;
        tick();
        chk("rst_snake", 32'(snake), 32'd0);
        chk("rst_head_x", 32'(head_x), 32'd20);
        chk("rst_head_y", 32'(head_y), 32'd15);
        chk("rst_length", 32'(length), 32'd3);
        chk("rst_game_over", 32'(game_over), 32'd0);
        rst = 1'b1;
        query(320, 240, 2'b01, "q_head");
        query(304, 240, 2'b10, "q_body");
        query(288, 240, 2'b10, "q_tail");
        query(272, 240, 2'b00, "q_beyond_tail");
        query(0, 0, 2'b11, "q_wall_corner");
        query(639, 240, 2'b11, "q_wall_right");
        query(700, 10, 2'b00, "q_off_x");
        query(100, 480, 2'b00, "q_off_y");

        // 2: three moves right
        do_reset();
        for (int i = 0; i < 3; i++) step(2'b11, 1'b0);
        chk("t2_head_x", 32'(head_x), 32'd23);
        chk("t2_head_y", 32'(head_y), 32'd15);
        chk("t2_length", 32'(length), 32'd3);
        query(320, 240, 2'b00, "t2_old_cell");
        query(368, 240, 2'b01, "t2_new_head");
        query(336, 240, 2'b10, "t2_new_tail");

        // 3: reversal ignored; then a standalone grow pulse applied at the next move
        do_reset();
        step(2'b10, 1'b0);
        chk("t3_head_x", 32'(head_x), 32'd21);
        chk("t3_head_y", 32'(head_y), 32'd15);
        grow = 1'b1;
        tick();
        grow = 1'b0;
        tick();
        chk("t3_len_before_move", 32'(length), 32'd3);
        step(2'b11, 1'b0);
        chk("t3_len_after_move", 32'(length), 32'd4);
        step(2'b11, 1'b0);
        chk("t3_len_pend_cleared", 32'(length), 32'd4);

        // 4: coincident grow, then saturation at 16 with tail drop
        do_reset();
        step(2'b11, 1'b1);
        chk("t4_length", 32'(length), 32'd4);
        query(288, 240, 2'b10, "t4_tail_kept");
        for (int i = 0; i < 13; i++) step(2'b11, 1'b1);
        chk("t4_len_sat", 32'(length), 32'd16);
        chk("t4_head_x", 32'(head_x), 32'd34);
        chk("t4_alive", 32'(game_over), 32'd0);
        query(288, 240, 2'b00, "t4_tail_dropped");
        query(304, 240, 2'b10, "t4_new_tail");

        // 5: run into the right wall
        do_reset();
        for (int i = 0; i < 18; i++) step(2'b11, 1'b0);
        chk("t5_head_38", 32'(head_x), 32'd38);
        chk("t5_alive_38", 32'(game_over), 32'd0);
        step(2'b11, 1'b0);
        chk("t5_game_over", 32'(game_over), 32'd1);
        chk("t5_head_frozen", 32'(head_x), 32'd38);
        step(2'b11, 1'b1);
        step(2'b00, 1'b0);
        chk("t5_ignored_x", 32'(head_x), 32'd38);
        chk("t5_ignored_y", 32'(head_y), 32'd15);
        chk("t5_ignored_len", 32'(length), 32'd3);
        query(608, 240, 2'b01, "t5_dead_query");
        restart = 1'b1;
        tick();
        restart = 1'b0;
        chk("t5_restart_x", 32'(head_x), 32'd20);
        chk("t5_restart_y", 32'(head_y), 32'd15);
        chk("t5_restart_go", 32'(game_over), 32'd0);
        chk("t5_restart_len", 32'(length), 32'd3);
        step(2'b11, 1'b0);
        chk("t5_runs_again", 32'(head_x), 32'd21);

        // 6a: length 5, U-turn into own body
        do_reset();
        step(2'b11, 1'b1);
        step(2'b11, 1'b1);
        chk("t6a_length", 32'(length), 32'd5);
        step(2'b00, 1'b0);
        step(2'b10, 1'b0);
        chk("t6a_alive", 32'(game_over), 32'd0);
        step(2'b01, 1'b0);
        chk("t6a_dead", 32'(game_over), 32'd1);
        chk("t6a_head_x", 32'(head_x), 32'd21);
        chk("t6a_head_y", 32'(head_y), 32'd14);

        // 6b: length 4 chasing its tail around a 2x2 loop
        do_reset();
        step(2'b11, 1'b1);
        step(2'b00, 1'b0);
        step(2'b10, 1'b0);
        step(2'b01, 1'b0);
        step(2'b11, 1'b0);
        step(2'b00, 1'b0);
        step(2'b10, 1'b0);
        chk("t6b_alive", 32'(game_over), 32'd0);
        chk("t6b_head_x", 32'(head_x), 32'd20);
        chk("t6b_head_y", 32'(head_y), 32'd14);
        chk("t6b_length", 32'(length), 32'd4);
        query(336, 240, 2'b10, "t6b_body_cell");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
